strobe_period_monitor: RTL
==========================

// Module: strobe_period_monitor
// PURPOSE
//   Receive-side checker for the periodic strobes from the strobe generators
//   (clk_ten, every_us, every_second, ...). Measures the clk-cycle distance
//   between consecutive rising edges of one strobe, checks it against an
//   expected period, and reports lock, period errors and missing strobes.
//   One instance per monitored strobe; used in self-test and by the bench.
// PARAMETERS
//   EXPECTED   100  expected period in clk cycles (>= 2)
//   TOLERANCE  0    allowed |period - EXPECTED| in cycles
//   LOCK_COUNT 4    consecutive good periods required to assert locked (1..15)
//   CNT_WIDTH  32   counter/period width; must hold 2*EXPECTED+TOLERANCE
// PORTS
//   clk        in   1          system clock
//   rst        in   1          async reset, active-low
//   enable     in   1          1 = monitor running; 0 = idle
//   strobe_in  in   1          strobe under test, synchronous to clk
//   clear_err  in   1          1-cycle pulse: clear error and err_count
//   period     out  CNT_WIDTH  last measured period in clk cycles
//   period_vld out  1          1-cycle pulse: period updated this cycle
//   locked     out  1          LOCK_COUNT consecutive in-tolerance periods
//   error      out  1          sticky: any bad period or missing strobe
//   missing    out  1          1-cycle pulse: timeout, no edge in window
//   err_count  out  8          bad-period + missing events, saturates at 255
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; period=0, period_vld=0, locked=0,
//     error=0, missing=0, err_count=0; cnt=0, good=0, strobe_d=0.
//   Edge detect: rise = strobe_in & ~strobe_d; strobe_d registered every cycle.
//     Only rising edges count; width of strobe_in high is irrelevant.
//   FSM:
//     IDLE  : enable=1 -> ARM. Edges ignored.
//     ARM   : waits for first rise; on rise cnt<=0 -> MEASURE. No period output,
//             no timeout in ARM.
//     MEASURE: cnt increments each cycle. On rise: period<=cnt+1, period_vld=1,
//             cnt<=0. Rises at clk edges t and t+N yield period=N. Outputs are
//             registered at the same edge that samples the rise.
//   Good period: |cnt+1 - EXPECTED| <= TOLERANCE -> good++ (saturate at
//     LOCK_COUNT); locked<=1 when good reaches LOCK_COUNT.
//   Bad period: period still reported; error<=1; err_count++ (sat 255);
//     good<=0; locked<=0.
//   Timeout: in MEASURE, if cnt+1 == 2*EXPECTED+TOLERANCE with no rise this
//     cycle: missing=1 for one cycle, error<=1, err_count++, good<=0,
//     locked<=0, cnt<=0, -> ARM. Rise on that same cycle is a normal edge.
//   clear_err: error<=0, err_count<=0 next edge; if an error event occurs the
//     same cycle, event wins: error=1, err_count=1.
//   enable=0 (any state, sync): -> IDLE; cnt, good, locked cleared; period,
//     error, err_count retained; period_vld/missing forced 0.
//   Reset mid-measurement: everything to reset values; first period after
//     reset is never reported (ARM discards partial interval).
// TESTING
//   1 EXPECTED=10: rises every 10 clk, 6 edges -> 5 period_vld with period=10;
//     locked rises at 4th pulse; error=0, err_count=0.
//   2 Locked, one interval of 12 (TOLERANCE=0) -> period=12, error=1,
//     err_count=1, locked=0; 4 more good periods -> locked=1, error stays 1.
//   3 Locked, stop strobe -> missing pulses exactly 20 clk after last rise,
//     err_count+1, state ARM; restart strobe -> first rise gives no period_vld.
//   4 TOLERANCE=1: periods 9,11,10,9 -> no error, locked after 4th; period 8
//     -> error=1.
//   5 clear_err coincident with bad period -> error=1, err_count=1; clear_err
//     alone next -> error=0, err_count=0. 300 bad periods -> err_count=255.
//   6 rst low mid-interval / enable low while locked -> all outputs per reset
//     rules; enable=0 keeps period and error, drops locked.

Source files
------------

// File: rtl/strobe_period_monitor.sv
// Receive-side checker for a periodic strobe. Measures the clk-cycle distance
// between consecutive rising edges, compares it with an expected period and
// reports lock, bad periods and missing strobes.
//
// Handshake: period_vld is a single-cycle qualifier with no ready; period is
// valid while period_vld is high and holds its value until the next update.
module strobe_period_monitor #(
  parameter int EXPECTED   = 100,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 strobe_in,
  input  logic                 clear_err,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_vld,
  output logic                 locked,
  output logic                 error,
  output logic                 missing,
  output logic [7:0]           err_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] EXP_C = CNT_WIDTH'(EXPECTED);
  localparam logic [CNT_WIDTH-1:0] TOL_C = CNT_WIDTH'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] TMO_C = CNT_WIDTH'(2 * EXPECTED + TOLERANCE);
  localparam logic [3:0]           LOCK_C = 4'(LOCK_COUNT);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [3:0]           good;
  logic                 strobe_d;

  logic                 rise;
  logic [CNT_WIDTH-1:0] meas;
  logic                 in_tol;
  logic                 timeout;
  logic [3:0]           good_inc;
  logic                 err_evt;

  assign state_dbg = state;

  // Rising edge of the strobe and the interval it closes (cnt counts from 0).
  assign rise    = strobe_in & ~strobe_d;
  assign meas    = cnt + CNT_WIDTH'(1);
  assign in_tol  = (meas >= EXP_C) ? ((meas - EXP_C) <= TOL_C)
                                   : ((EXP_C - meas) <= TOL_C);
  assign timeout = (meas == TMO_C);
  assign good_inc = (good == LOCK_C) ? good : good + 4'd1;

  // An error event is a bad period or a timeout while measuring.
  assign err_evt = enable && (state == MEASURE) &&
                   ((rise && !in_tol) || (!rise && timeout));

  // Edge detect, measurement FSM, lock tracking and sticky error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      good       <= '0;
      strobe_d   <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      missing    <= 1'b0;
      err_count  <= '0;
    end else begin
      strobe_d   <= strobe_in;
      period_vld <= 1'b0;
      missing    <= 1'b0;

      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        good   <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            // The partial interval before the first edge is discarded.
            if (rise) begin
              cnt   <= '0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period     <= meas;
              period_vld <= 1'b1;
              cnt        <= '0;
              if (in_tol) begin
                good   <= good_inc;
                locked <= (good_inc == LOCK_C);
              end else begin
                good   <= '0;
                locked <= 1'b0;
              end
            end else if (timeout) begin
              missing <= 1'b1;
              good    <= '0;
              locked  <= 1'b0;
              cnt     <= '0;
              state   <= ARM;
            end else begin
              cnt <= meas;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A same-cycle error event beats clear_err and restarts the count at 1.
      if (err_evt) begin
        error     <= 1'b1;
        err_count <= clear_err ? 8'd1
                   : ((err_count == 8'd255) ? err_count : err_count + 8'd1);
      end else if (clear_err) begin
        error     <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule
